// File: rtl/encoder83_debounce.sv
// rtl/encoder83_debounce.sv - 8-to-3 encoder with synchroniser, debounce, valid/ack handshake and release detection; optional multi-line error via ENCODER83_MULTI_ERR_EN
module encoder83_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_y,
    input  logic       i_opt,
    input  logic       i_ack,
    output logic [2:0] o_sel,
    output logic       o_valid,
    output logic       o_err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_PEND   = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    // Terminal count: the candidate has been seen DEBOUNCE_CYCLES times in a row
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [7:0] sync1_q;
    logic [7:0] sync2_q;
    logic [7:0] act;

    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cand_q, cand_d;
    logic [2:0] sel_q, sel_d;
    logic       valid_q, valid_d;

    // Lowest set bit wins when several lines are active at once
    function automatic logic [2:0] lowest_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // Two-flop synchroniser; reset loads the idle level so no phantom press appears
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q <= {8{~i_opt}};
            sync2_q <= {8{~i_opt}};
        end else begin
            sync1_q <= i_y;
            sync2_q <= sync1_q;
        end
    end

    // Normalise polarity so a 1 always means "line active"
    assign act = i_opt ? sync2_q : ~sync2_q;

`ifdef ENCODER83_MULTI_ERR_EN
    logic err_q, err_d;

    // More than one bit set in the candidate vector
    function automatic logic multi_line(input logic [7:0] v);
        return (v & (v - 8'd1)) != 8'd0;
    endfunction
`endif

    // Next-state logic for the press/settle/pending/release sequence
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        sel_d   = sel_q;
        valid_d = valid_q;
`ifdef ENCODER83_MULTI_ERR_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (act != 8'd0) begin
                    cand_d  = act;
                    cnt_d   = 8'd1;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (act == 8'd0) begin
                    state_d = ST_IDLE;
                end else if (act != cand_q) begin
                    // Bounce onto a different line restarts the count
                    cand_d = act;
                    cnt_d  = 8'd1;
                end else if (cnt_q < CNT_LAST) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
`ifdef ENCODER83_MULTI_ERR_EN
                    if (multi_line(cand_q)) begin
                        // Reject the chord and wait for a full release
                        err_d   = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = ST_HOLD;
                    end else begin
                        sel_d   = lowest_index(cand_q);
                        valid_d = 1'b1;
                        state_d = ST_PEND;
                    end
`else
                    sel_d   = lowest_index(cand_q);
                    valid_d = 1'b1;
                    state_d = ST_PEND;
`endif
                end
            end
            ST_PEND: begin
                // Code is frozen until the consumer acknowledges it
                if (i_ack) begin
                    valid_d = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Require a debounced release so a held key is reported only once
                if (act != 8'd0) begin
                    cnt_d = 8'd0;
                end else if (cnt_q < CNT_LAST) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset wins in every state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            cand_q  <= 8'd0;
            sel_q   <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

`ifdef ENCODER83_MULTI_ERR_EN
    // One-cycle error pulse register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    assign o_sel   = sel_q;
    assign o_valid = valid_q;

endmodule

// File: tb/tb_encoder83_debounce.sv
// tb/tb_encoder83_debounce.sv - self-checking bench for encoder83_debounce
module tb_encoder83_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] y;
    logic       opt;
    logic       ack;
    logic [2:0] sel;
    logic       valid;
    logic       err;

    int checks = 0;
    int errors = 0;

    encoder83_debounce #(.DEBOUNCE_CYCLES(4)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_y     (y),
        .i_opt   (opt),
        .i_ack   (ack),
        .o_sel   (sel),
        .o_valid (valid),
        .o_err   (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       opt;
        logic [7:0] y;
        int         hold;
        logic       exp_valid;
        logic [2:0] exp_sel;
        int         exp_lat;
        int         exp_err;
    } vec_t;

    typedef struct {
        logic       valid;
        logic [2:0] sel;
        int         lat;
        int         err;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act_v, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic o);
        opt = o;
        y   = {8{~o}};
        ack = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic push_exp(input logic v, input logic [2:0] s, input int lat, input int e);
        exp_t x;
        x.valid = v;
        x.sel   = s;
        x.lat   = lat;
        x.err   = e;
        exp_q.push_back(x);
    endtask

    // Edge k of the window is the k-th posedge after the stimulus was set
    task automatic observe(input string name, input int window, input int hold, input logic [7:0] idle);
        exp_t cur;
        logic popped = 1'b0;
        int   errs = 0;
        for (int k = 0; k < window; k++) begin
            tick();
            if (err) errs++;
            if (valid && !popped) begin
                popped = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s: unexpected valid sel %0d at edge %0d", name, sel, k);
                end else begin
                    cur = exp_q.pop_front();
                    check({name, " valid"}, 32'(valid), 32'(cur.valid));
                    check({name, " sel"}, 32'(sel), 32'(cur.sel));
                    check({name, " latency"}, k, cur.lat);
                end
            end
            if (hold > 0 && k + 1 == hold) y = idle;
        end
        if (!popped) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s: scoreboard empty", name);
                cur.err = 0;
            end else begin
                cur = exp_q.pop_front();
                check({name, " valid"}, 32'(1'b0), 32'(cur.valid));
            end
        end
        check({name, " err cycles"}, errs, cur.err);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        // opt, y, hold(0 = keep), valid, sel, latency, err cycles
        vecs[0] = '{1'b0, 8'b1111_0111, 0, 1'b1, 3'd3, 5, 0};
        vecs[1] = '{1'b0, 8'b0111_1111, 0, 1'b1, 3'd7, 5, 0};
        vecs[2] = '{1'b0, 8'b1110_1111, 3, 1'b0, 3'd0, 0, 0};
        vecs[3] = '{1'b0, 8'b1111_1011, 4, 1'b1, 3'd2, 5, 0};
        vecs[4] = '{1'b1, 8'b1000_0000, 0, 1'b1, 3'd7, 5, 0};
        vecs[5] = '{1'b1, 8'b0000_0001, 0, 1'b1, 3'd0, 5, 0};
        vecs[6] = '{1'b1, 8'b0000_0011, 2, 1'b0, 3'd0, 0, 0};
`ifdef ENCODER83_MULTI_ERR_EN
        vecs[7] = '{1'b1, 8'b0010_0100, 0, 1'b0, 3'd0, 0, 1};
        vecs[8] = '{1'b0, 8'b1010_1111, 0, 1'b0, 3'd0, 0, 1};
`else
        vecs[7] = '{1'b1, 8'b0010_0100, 0, 1'b1, 3'd2, 5, 0};
        vecs[8] = '{1'b0, 8'b1010_1111, 0, 1'b1, 3'd4, 5, 0};
`endif

        // Reset state and idle quiet period
        opt = 1'b0;
        y   = 8'hFF;
        ack = 1'b0;
        rst = 1'b1;
        tick();
        check("reset valid", 32'(valid), 0);
        check("reset sel", 32'(sel), 0);
        check("reset err", 32'(err), 0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (valid || sel != 3'd0 || err) bad++;
        end
        check("idle quiet cycles", bad, 0);

        // Table-driven presses, each from a fresh reset
        for (int v = 0; v < 9; v++) begin
            do_reset(vecs[v].opt);
            push_exp(vecs[v].exp_valid, vecs[v].exp_sel, vecs[v].exp_lat, vecs[v].exp_err);
            y = vecs[v].y;
            observe($sformatf("vec%0d", v), 14, vecs[v].hold, {8{~vecs[v].opt}});
        end

        // Held key: valid persists without ack, one report per press
        do_reset(1'b0);
        push_exp(1'b1, 3'd3, 5, 0);
        y = 8'b1111_0111;
        observe("held press", 8, 0, 8'hFF);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!valid) bad++;
        end
        check("valid held without ack", bad, 0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("valid after ack", 32'(valid), 0);
        check("sel kept after ack", 32'(sel), 3);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid) bad++;
        end
        check("no re-report while held", bad, 0);
        y = 8'hFF;
        for (int i = 0; i < 6; i++) tick();
        push_exp(1'b1, 3'd7, 5, 0);
        y = 8'b0111_1111;
        observe("second key", 8, 0, 8'hFF);

        // Ack held high from idle: ignored until PEND, then clears after one cycle
        do_reset(1'b0);
        ack = 1'b1;
        push_exp(1'b1, 3'd1, 5, 0);
        y = 8'b1111_1101;
        observe("ack early", 6, 0, 8'hFF);
        tick();
        check("ack early clears", 32'(valid), 0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid) bad++;
        end
        check("ack early no repeat", bad, 0);
        ack = 1'b0;

        // Bounce from line 5 onto line 6
        do_reset(1'b0);
        y = 8'b1101_1111;
        tick();
        tick();
        push_exp(1'b1, 3'd6, 5, 0);
        y = 8'b1011_1111;
        observe("bounce", 10, 0, 8'hFF);

        // Reset during PEND drops valid, key re-reported after reset release
        do_reset(1'b0);
        push_exp(1'b1, 3'd3, 5, 0);
        y = 8'b1111_0111;
        observe("pre-reset press", 8, 0, 8'hFF);
        rst = 1'b1;
        tick();
        check("valid dropped by reset", 32'(valid), 0);
        rst = 1'b0;
        push_exp(1'b1, 3'd3, 5, 0);
        observe("re-report after reset", 10, 0, 8'hFF);

        check("scoreboard drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
